// File: rtl/retire_trace_buffer.sv
// Retire-trace capture: queues one record per retired instruction in a FWFT FIFO for a ready/valid sink.
// Latency: record visible on out_* the cycle after the ret_valid edge; no same-cycle bypass into an empty FIFO.
// Backpressure: out_ready pops the head; full FIFO drops+counts (DROP_ON_FULL=1) or raises stall_req near full (0).
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   ret_*                               WB-stage retire probe (ret_valid is a one-cycle pulse per instruction)
//   exit_request, exit_code             program exit (level) and its code
//   out_valid/out_ready, out_*          head record {pc, instr, data, addr, flags}
//   stall_req                           registered near-full request (stall mode only)
//   retired_count, dropped_count        retires seen while running, records lost to a full FIFO
//   hang, done, done_code               sticky watchdog expiry, sticky exit-and-drained, latched exit code
module retire_trace_buffer #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned DROP_ON_FULL    = 1,
    parameter int unsigned STALL_MARGIN    = 2,
    parameter int unsigned WATCHDOG_CYCLES = 100000,
    parameter int unsigned WD_W            = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ret_valid,
    input  logic [31:0] ret_pc,
    input  logic [31:0] ret_instr,
    input  logic        ret_rd_write,
    input  logic [31:0] ret_rd_data,
    input  logic        ret_mem_valid,
    input  logic        ret_mem_write,
    input  logic [31:0] ret_mem_addr,
    input  logic [31:0] ret_mem_wdata,
    input  logic        exit_request,
    input  logic [31:0] exit_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic [2:0]  out_flags,
    output logic        stall_req,
    output logic [63:0] retired_count,
    output logic [31:0] dropped_count,
    output logic        hang,
    output logic        done,
    output logic [31:0] done_code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0]   STALL_TH = PW'(DEPTH - STALL_MARGIN);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0]  flags;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    rec_t            mem_q [DEPTH];
    rec_t            mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [63:0]     retired_count_q, retired_count_d;
    logic [31:0]     dropped_count_q, dropped_count_d;
    logic            stall_req_q, stall_req_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            hang_q, hang_d;
    logic            done_q, done_d;
    logic [31:0]     done_code_q, done_code_d;
    state_t          state_q, state_d;

    rec_t            rec_in;
    rec_t            head;
    logic            empty;
    logic            full;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            drop;
    logic [PW-1:0]   occ_next;

    // Record is assembled from the probe in the retire cycle itself.
    always_comb begin
        rec_in       = '0;
        rec_in.pc    = ret_pc;
        rec_in.instr = ret_instr;
        rec_in.data  = ret_rd_write ? ret_rd_data : ret_mem_wdata;
        rec_in.addr  = ret_mem_valid ? ret_mem_addr : 32'h0;
        rec_in.flags = {ret_rd_write, ret_mem_valid, ret_mem_write};
    end

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_req = ret_valid && (state_q == ST_RUN);
        pop      = !empty && out_ready;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_next = wr_ptr_d - rd_ptr_d;

        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = rec_in;
        end

        retired_count_d = retired_count_q + 64'(push_req);

        dropped_count_d = dropped_count_q;
        if (drop && (dropped_count_q != 32'hFFFF_FFFF)) begin
            dropped_count_d = dropped_count_q + 32'd1;
        end

        stall_req_d = (DROP_ON_FULL == 0) && (occ_next >= STALL_TH);
    end

    // Exit sequencing: the retire in the exit cycle is kept; afterwards the
    // FIFO is only drained, and DONE is entered once nothing remains.
    always_comb begin
        state_d     = state_q;
        done_code_d = done_code_q;
        case (state_q)
            ST_RUN: begin
                if (exit_request) begin
                    done_code_d = exit_code;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        done_d = done_q || (state_d == ST_DONE);
    end

    // Watchdog counts idle RUN cycles and saturates at the limit; frozen once exiting.
    always_comb begin
        wd_d   = wd_q;
        hang_d = hang_q;
        if ((WATCHDOG_CYCLES != 0) && (state_q == ST_RUN)) begin
            if (ret_valid) begin
                wd_d = '0;
            end else if (wd_q != WD_LIMIT) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (wd_d == WD_LIMIT) begin
                hang_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            retired_count_q <= '0;
            dropped_count_q <= '0;
            stall_req_q     <= 1'b0;
            wd_q            <= '0;
            hang_q          <= 1'b0;
            done_q          <= 1'b0;
            done_code_q     <= '0;
            state_q         <= ST_RUN;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            retired_count_q <= retired_count_d;
            dropped_count_q <= dropped_count_d;
            stall_req_q     <= stall_req_d;
            wd_q            <= wd_d;
            hang_q          <= hang_d;
            done_q          <= done_d;
            done_code_q     <= done_code_d;
            state_q         <= state_d;
        end
    end

    assign out_valid     = !empty;
    assign out_pc        = head.pc;
    assign out_instr     = head.instr;
    assign out_data      = head.data;
    assign out_addr      = head.addr;
    assign out_flags     = head.flags;
    assign stall_req     = stall_req_q;
    assign retired_count = retired_count_q;
    assign dropped_count = dropped_count_q;
    assign hang          = hang_q;
    assign done          = done_q;
    assign done_code     = done_code_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench: u_a is DEPTH=4 drop mode with a 10-cycle watchdog, u_b is DEPTH=8 stall mode.
// Both instances share the same input stimulus; each test checks the instance it targets.
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [31:0] ret_instr = '0;
    logic        ret_rd_write = 1'b0;
    logic [31:0] ret_rd_data = '0;
    logic        ret_mem_valid = 1'b0;
    logic        ret_mem_write = 1'b0;
    logic [31:0] ret_mem_addr = '0;
    logic [31:0] ret_mem_wdata = '0;
    logic        exit_request = 1'b0;
    logic [31:0] exit_code = '0;
    logic        out_ready = 1'b0;

    logic        a_out_valid, b_out_valid;
    logic [31:0] a_out_pc, b_out_pc, a_out_instr, b_out_instr;
    logic [31:0] a_out_data, b_out_data, a_out_addr, b_out_addr;
    logic [2:0]  a_out_flags, b_out_flags;
    logic        a_stall_req, b_stall_req;
    logic [63:0] a_retired, b_retired;
    logic [31:0] a_dropped, b_dropped;
    logic        a_hang, b_hang, a_done, b_done;
    logic [31:0] a_done_code, b_done_code;

    int vectors = 0;
    int miscompares = 0;

    // Test 1 stimulus and hand-derived expectations.
    logic [31:0] t_pc    [5] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
    logic [31:0] t_instr [5] = '{32'h00100093, 32'h0000A103, 32'h0020A023, 32'h00000013, 32'h00208133};
    logic        t_rdw   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_rdd   [5] = '{32'h11, 32'h22, 32'h33, 32'h66, 32'h88};
    logic        t_mv    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        t_mw    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_ma    [5] = '{32'hDEAD0000, 32'h2000, 32'h2004, 32'h3000, 32'h4000};
    logic [31:0] t_mwd   [5] = '{32'hBEEF, 32'h55, 32'h44, 32'h77, 32'h99};
    logic [31:0] e_data  [5] = '{32'h11, 32'h22, 32'h44, 32'h77, 32'h88};
    logic [31:0] e_addr  [5] = '{32'h0, 32'h2000, 32'h2004, 32'h0, 32'h0};
    logic [2:0]  e_flags [5] = '{3'b100, 3'b110, 3'b011, 3'b000, 3'b100};

    retire_trace_buffer #(.DEPTH(4), .DROP_ON_FULL(1), .STALL_MARGIN(2), .WATCHDOG_CYCLES(10), .WD_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_rd_write(ret_rd_write), .ret_rd_data(ret_rd_data), .ret_mem_valid(ret_mem_valid),
        .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
        .exit_request(exit_request), .exit_code(exit_code), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_instr(a_out_instr), .out_data(a_out_data), .out_addr(a_out_addr),
        .out_flags(a_out_flags), .stall_req(a_stall_req), .retired_count(a_retired),
        .dropped_count(a_dropped), .hang(a_hang), .done(a_done), .done_code(a_done_code)
    );

    retire_trace_buffer #(.DEPTH(8), .DROP_ON_FULL(0), .STALL_MARGIN(2), .WATCHDOG_CYCLES(0), .WD_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_rd_write(ret_rd_write), .ret_rd_data(ret_rd_data), .ret_mem_valid(ret_mem_valid),
        .ret_mem_write(ret_mem_write), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
        .exit_request(exit_request), .exit_code(exit_code), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_instr(b_out_instr), .out_data(b_out_data), .out_addr(b_out_addr),
        .out_flags(b_out_flags), .stall_req(b_stall_req), .retired_count(b_retired),
        .dropped_count(b_dropped), .hang(b_hang), .done(b_done), .done_code(b_done_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_rd_write = 1'b0; ret_rd_data = '0;
        ret_mem_valid = 1'b0; ret_mem_write = 1'b0; ret_mem_addr = '0; ret_mem_wdata = '0;
        exit_request = 1'b0; exit_code = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive_ret(input logic [31:0] pc, input logic [31:0] instr, input logic rdw,
                             input logic [31:0] rdd, input logic mv, input logic mw,
                             input logic [31:0] ma, input logic [31:0] mwd);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_rd_write = rdw; ret_rd_data = rdd;
        ret_mem_valid = mv; ret_mem_write = mw; ret_mem_addr = ma; ret_mem_wdata = mwd;
    endtask

    task automatic drive_pc(input logic [31:0] pc);
        drive_ret(pc, 32'h00000013, 1'b1, pc ^ 32'hFFFF, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
        vectors++; if (a_out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_a_pc: got %h want 0", a_out_pc); end
        vectors++; if (a_out_flags !== 3'b0) begin miscompares++; $display("FAIL reset_a_flags: got %b want 0", a_out_flags); end
        vectors++; if (a_retired !== 64'h0) begin miscompares++; $display("FAIL reset_a_retired: got %0d want 0", a_retired); end
        vectors++; if (a_dropped !== 32'h0) begin miscompares++; $display("FAIL reset_a_dropped: got %0d want 0", a_dropped); end
        vectors++; if ({a_hang, a_done, a_stall_req} !== 3'b0) begin miscompares++; $display("FAIL reset_a_flags_out: got %b want 000", {a_hang, a_done, a_stall_req}); end
        vectors++; if (a_done_code !== 32'h0) begin miscompares++; $display("FAIL reset_a_done_code: got %h want 0", a_done_code); end
        vectors++; if ({b_out_valid, b_stall_req, b_hang, b_done} !== 4'b0) begin miscompares++; $display("FAIL reset_b_flags: got %b want 0000", {b_out_valid, b_stall_req, b_hang, b_done}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_order();
        int idx;
        do_reset();
        out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 15 && idx < 5; cyc++) begin
            if (cyc < 5) drive_ret(t_pc[cyc], t_instr[cyc], t_rdw[cyc], t_rdd[cyc], t_mv[cyc], t_mw[cyc], t_ma[cyc], t_mwd[cyc]);
            else ret_valid = 1'b0;
            step();
            if (a_out_valid) begin
                vectors++; if (a_out_pc !== t_pc[idx]) begin miscompares++; $display("FAIL basic_pc[%0d]: got %h want %h", idx, a_out_pc, t_pc[idx]); end
                vectors++; if (a_out_instr !== t_instr[idx]) begin miscompares++; $display("FAIL basic_instr[%0d]: got %h want %h", idx, a_out_instr, t_instr[idx]); end
                vectors++; if (a_out_data !== e_data[idx]) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", idx, a_out_data, e_data[idx]); end
                vectors++; if (a_out_addr !== e_addr[idx]) begin miscompares++; $display("FAIL basic_addr[%0d]: got %h want %h", idx, a_out_addr, e_addr[idx]); end
                vectors++; if (a_out_flags !== e_flags[idx]) begin miscompares++; $display("FAIL basic_flags[%0d]: got %b want %b", idx, a_out_flags, e_flags[idx]); end
                idx++;
            end
        end
        ret_valid = 1'b0;
        step();
        vectors++; if (idx !== 5) begin miscompares++; $display("FAIL basic_count: got %0d records want 5", idx); end
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty: got %b want 0", a_out_valid); end
        vectors++; if (a_retired !== 64'd5) begin miscompares++; $display("FAIL basic_retired: got %0d want 5", a_retired); end
    endtask

    task automatic test_drop_on_full();
        int n;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_pc(32'h2000 + 32'(4 * i));
            step();
        end
        ret_valid = 1'b0;
        vectors++; if (a_dropped !== 32'd3) begin miscompares++; $display("FAIL drop_count: got %0d want 3", a_dropped); end
        vectors++; if (a_retired !== 64'd7) begin miscompares++; $display("FAIL drop_retired: got %0d want 7", a_retired); end
        out_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 12 && n < 4; cyc++) begin
            if (a_out_valid) begin
                vectors++; if (a_out_pc !== 32'h2000 + 32'(4 * n)) begin miscompares++; $display("FAIL drop_pc[%0d]: got %h want %h", n, a_out_pc, 32'h2000 + 32'(4 * n)); end
                n++;
            end
            step();
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL drop_held: got %0d records want 4", n); end
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_empty: got %b want 0", a_out_valid); end
    endtask

    task automatic test_full_push_pop();
        int n;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pc(32'h3000 + 32'(4 * i));
            step();
        end
        drive_pc(32'h3010);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++; if (a_dropped !== 32'd0) begin miscompares++; $display("FAIL fullpp_dropped: got %0d want 0", a_dropped); end
        vectors++; if (a_out_pc !== 32'h3004) begin miscompares++; $display("FAIL fullpp_head: got %h want 3004", a_out_pc); end
        // Still full: one more push without a pop must be lost.
        drive_pc(32'h3014);
        step();
        ret_valid = 1'b0;
        vectors++; if (a_dropped !== 32'd1) begin miscompares++; $display("FAIL fullpp_still_full: got %0d want 1", a_dropped); end
        out_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 12 && n < 4; cyc++) begin
            if (a_out_valid) begin
                vectors++; if (a_out_pc !== 32'h3004 + 32'(4 * n)) begin miscompares++; $display("FAIL fullpp_pc[%0d]: got %h want %h", n, a_out_pc, 32'h3004 + 32'(4 * n)); end
                n++;
            end
            step();
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL fullpp_count: got %0d want 4", n); end
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL fullpp_empty: got %b want 0", a_out_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_pc(32'h4000 + 32'(4 * i));
            step();
            vectors++; if (b_stall_req !== (i == 5)) begin miscompares++; $display("FAIL stall_after_push%0d: got %b want %b", i + 1, b_stall_req, (i == 5)); end
        end
        vectors++; if (a_stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_drop_mode: got %b want 0", a_stall_req); end
        for (int i = 6; i < 9; i++) begin
            drive_pc(32'h4000 + 32'(4 * i));
            step();
        end
        ret_valid = 1'b0;
        vectors++; if (b_dropped !== 32'd1) begin miscompares++; $display("FAIL stall_overrun_drop: got %0d want 1", b_dropped); end
        vectors++; if (b_stall_req !== 1'b1) begin miscompares++; $display("FAIL stall_held: got %b want 1", b_stall_req); end
        vectors++; if (b_out_pc !== 32'h4000) begin miscompares++; $display("FAIL stall_head: got %h want 4000", b_out_pc); end
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_pc(32'h5000);
        step();
        ret_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            vectors++; if (a_hang !== (n >= 10)) begin miscompares++; $display("FAIL wd_cycle%0d: got %b want %b", n, a_hang, (n >= 10)); end
        end
        drive_pc(32'h5004);
        step();
        ret_valid = 1'b0;
        vectors++; if (a_hang !== 1'b1) begin miscompares++; $display("FAIL wd_sticky: got %b want 1", a_hang); end
        vectors++; if (b_hang !== 1'b0) begin miscompares++; $display("FAIL wd_disabled: got %b want 0", b_hang); end
    endtask

    task automatic test_exit_drain();
        int n;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pc(32'h6000 + 32'(4 * i));
            step();
        end
        drive_pc(32'h600C);
        exit_request = 1'b1;
        exit_code = 32'h2A;
        step();
        exit_code = 32'h55;
        drive_pc(32'h7000);
        step();
        ret_valid = 1'b0;
        vectors++; if (a_retired !== 64'd4) begin miscompares++; $display("FAIL exit_retired: got %0d want 4", a_retired); end
        vectors++; if (a_done !== 1'b0) begin miscompares++; $display("FAIL exit_done_early: got %b want 0", a_done); end
        vectors++; if (a_done_code !== 32'h2A) begin miscompares++; $display("FAIL exit_code_latch: got %h want 2a", a_done_code); end
        out_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 12 && n < 4; cyc++) begin
            if (a_out_valid) begin
                vectors++; if (a_out_pc !== 32'h6000 + 32'(4 * n)) begin miscompares++; $display("FAIL exit_pc[%0d]: got %h want %h", n, a_out_pc, 32'h6000 + 32'(4 * n)); end
                n++;
            end
            step();
        end
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL exit_drained: got %0d want 4", n); end
        vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL exit_done: got %b want 1", a_done); end
        drive_pc(32'h8000);
        step();
        ret_valid = 1'b0;
        exit_request = 1'b0;
        step();
        vectors++; if (a_done !== 1'b1) begin miscompares++; $display("FAIL exit_done_sticky: got %b want 1", a_done); end
        vectors++; if (a_retired !== 64'd4) begin miscompares++; $display("FAIL exit_done_ignores: got %0d want 4", a_retired); end
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL exit_done_empty: got %b want 0", a_out_valid); end
        vectors++; if (a_done_code !== 32'h2A) begin miscompares++; $display("FAIL exit_code_final: got %h want 2a", a_done_code); end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_drop_on_full();
        test_full_push_pop();
        test_stall();
        test_watchdog();
        test_exit_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
